// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
//   state_e   : transmitter FSM states (idle / shifting a word out)
//   cnt_width : bit-counter width for an N-bit word
package piso_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // $clog2 wrapper; N >= 2 always yields at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Bit-position counter for the serialiser.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset (count -> 0)
//   clear : load zero (takes priority over inc)
//   inc   : advance by one
//   count : current bit index, 0..N-1
//   tc    : terminal count, high when count == N-1
module shift_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned CntW = cnt_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            inc,
  output logic [CntW-1:0] count,
  output logic            tc
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == CntW'(N - 1));

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter. Accepts an N-bit word on a valid/ready
// handshake and shifts it out one bit per clock; back-to-back words are sent
// with no idle gap by reloading on the last bit.
//   clk          : rising-edge clock
//   reset        : synchronous active-low reset
//   load_valid   : parallel_in holds a word to send
//   parallel_in  : word to serialise, sampled only on accept
//   load_ready   : a word can be accepted this cycle
//   serial_out   : current serial bit (0 when not valid)
//   serial_valid : serial_out carries a data bit
//   frame_last   : high with the final bit of each word
//   busy         : a word is in flight (same as serial_valid)
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  input  logic [N-1:0] parallel_in,
  output logic         load_ready,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         frame_last,
  output logic         busy
);

  localparam int unsigned CntW = cnt_width(N);

  state_e          state_q, state_d;
  logic [N-1:0]    sreg_q, sreg_d;
  logic [CntW-1:0] bit_cnt;
  logic            cnt_tc;
  logic            cnt_clear;
  logic            cnt_inc;
  logic            in_shift;
  logic            accept;

  assign in_shift = (state_q == StShift);
  // load_ready depends only on state and counter, so this has no loop.
  assign accept   = load_valid && load_ready;

  // Counter is cleared on every accept and when a word finishes, so it sits
  // at zero in idle and never runs past N-1.
  assign cnt_clear = accept || (in_shift && cnt_tc);
  assign cnt_inc   = in_shift && !cnt_tc;

  shift_bit_counter #(
    .N (N)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (bit_cnt),
    .tc    (cnt_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StShift;
      end
      StShift: begin
        if (cnt_tc && !accept) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    load_ready   = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    frame_last   = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      StIdle: begin
        load_ready = 1'b1;
      end
      StShift: begin
        load_ready   = cnt_tc;
        serial_out   = MSB_FIRST ? sreg_q[N-1] : sreg_q[0];
        serial_valid = 1'b1;
        frame_last   = cnt_tc;
        busy         = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift register: load on accept, otherwise shift with zero fill.
  always_comb begin
    sreg_d = sreg_q;
    if (accept) begin
      sreg_d = parallel_in;
    end else if (in_shift) begin
      if (MSB_FIRST) begin
        sreg_d = {sreg_q[N-2:0], 1'b0};
      end else begin
        sreg_d = {1'b0, sreg_q[N-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  logic unused_cnt;
  assign unused_cnt = ^bit_cnt;

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in serial-out transmitter for the storage-register family: accepts an N-bit word through a valid/ready load handshake and shifts it out one bit per clock, with a per-bit valid strobe and a last-bit marker. It is the serialising end paired with the parallel storage registers and feeds any serial-in consumer (SIPO or a serial link). It supports back-to-back words with no idle gap.

## Interface
- N, default 4: word width; legal range N ≥ 2.
- MSB_FIRST, default 1: 1 sends bit N-1 first; 0 sends bit 0 first.

- clk  input  1  rising-edge clock; sole clock.
- reset  input  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- load_valid  input  1  parallel_in holds a word to send.
- parallel_in  input  N  word to serialise; sampled only on an accepted load.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  current serial bit, registered.
- serial_valid  output  1  serial_out carries a data bit this cycle.
- frame_last  output  1  high with the final bit of each word.
- busy  output  1  a word is in flight (equals serial_valid).

## Operation
- States are IDLE and SHIFT.
- Accept means load_valid && load_ready at a rising edge.
- In IDLE, load_ready = 1. On accept, the word goes to the shift register, bit_cnt is set to 0, and the state moves to SHIFT.
- In SHIFT, the current bit is driven, serial_valid = 1, and bit_cnt increments each cycle.
- frame_last = 1 when bit_cnt == N-1.
- load_ready = 1 in SHIFT only when bit_cnt == N-1 (last bit).
  - Accept on the last bit: reload, bit_cnt = 0, stay in SHIFT. The next word's first bit follows the last bit with zero gap.
  - No accept on the last bit: go to IDLE, and serial_valid drops the next cycle.
- Shift order:
  - MSB_FIRST = 1: serial_out = sreg[N-1], then shift left with a 0 fill.
  - MSB_FIRST = 0: serial_out = sreg[0], then shift right with a 0 fill.
- parallel_in is ignored when there is no accept. Changing it mid-word does not affect the word in flight.
- load_valid may deassert at any time without an accept. Nothing is queued.
- bit_cnt width is $clog2(N). It never exceeds N-1 and never wraps past N-1; it resets to 0 on reload.

## Timing
- Reset (reset == 0 at an edge) takes priority over everything, including an accept in the same cycle.
- After reset: state = IDLE, sreg = 0, bit_cnt = 0, serial_out = 0, serial_valid = 0, frame_last = 0, busy = 0, load_ready = 1.
- Reset mid-word abandons the word. No partial frame_last is produced.
- Latency: accept at edge k puts the first bit on serial_out after edge k, valid during cycle k+1. The last bit is valid during cycle k+N.
- Throughput: one N-bit word per N cycles sustained.
- When serial_valid = 0, serial_out = 0.
- load_ready is combinational from state and bit_cnt only. It has no path from load_valid.

## Structure
- Package piso_pkg holds:
  - the state enum typedef (IDLE, SHIFT);
  - the function for counter width (clog2 wrapper).
- One sub-module, shift_bit_counter: a $clog2(N)-bit counter with load-zero, increment and a terminal-count (== N-1) output. It drives frame_last and load_ready.
- The shift register and FSM live in the top module.

## Test plan
- Reset then idle (N=4): hold reset = 0 for 2 cycles, then release with load_valid = 0 → all outputs 0 except load_ready = 1, stable for 10 cycles.
- Single word, MSB first: parallel_in = 4'b1011, accept at edge k → serial_out sequence 1,0,1,1 in cycles k+1..k+4.
  - serial_valid high for exactly those 4 cycles.
  - frame_last high only in cycle k+4.
  - load_ready low in k+1..k+3.
- LSB first (MSB_FIRST = 0): 4'b1011 → sequence 1,1,0,1.
- Back-to-back: 4'b1011 then 4'b0110, with load_valid held high → 8 contiguous valid bits 1,0,1,1,0,1,1,0.
  - frame_last in bits 4 and 8.
  - No gap cycle.
- Input disturbance: change parallel_in to 4'b0000 and pulse load_valid during bits 2–3 of 4'b1011 → output unaffected, no accept registered.
- Reset mid-word: assert reset after bit 2 of 4'b1011 → next cycle serial_valid = 0, serial_out = 0, frame_last never asserted, load_ready = 1. A new load afterwards sends a full 4-bit word.
